// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (active-low, bit6..0 = g,f,e,d,c,b,a) and BCD nibble codes.
// Used by both the display encoder and the read-back decoder.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h40;
  localparam logic [6:0] SEG7_1     = 7'h79;
  localparam logic [6:0] SEG7_2     = 7'h24;
  localparam logic [6:0] SEG7_3     = 7'h30;
  localparam logic [6:0] SEG7_4     = 7'h19;
  localparam logic [6:0] SEG7_5     = 7'h12;
  localparam logic [6:0] SEG7_6     = 7'h02;
  localparam logic [6:0] SEG7_7     = 7'h78;
  localparam logic [6:0] SEG7_8     = 7'h00;
  localparam logic [6:0] SEG7_9     = 7'h10;
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam logic [3:0] BCD_ERR    = 4'hF;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational lookup from an active-low 7-segment pattern to {err, nibble}.
// Blank decodes to F without error; anything unrecognised decodes to F with error.
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = BCD_ERR;
    err    = 1'b1;
    case (pattern)
      SEG7_0:     begin nibble = 4'd0;      err = 1'b0; end
      SEG7_1:     begin nibble = 4'd1;      err = 1'b0; end
      SEG7_2:     begin nibble = 4'd2;      err = 1'b0; end
      SEG7_3:     begin nibble = 4'd3;      err = 1'b0; end
      SEG7_4:     begin nibble = 4'd4;      err = 1'b0; end
      SEG7_5:     begin nibble = 4'd5;      err = 1'b0; end
      SEG7_6:     begin nibble = 4'd6;      err = 1'b0; end
      SEG7_7:     begin nibble = 4'd7;      err = 1'b0; end
      SEG7_8:     begin nibble = 4'd8;      err = 1'b0; end
      SEG7_9:     begin nibble = 4'd9;      err = 1'b0; end
      SEG7_BLANK: begin nibble = BCD_BLANK; err = 1'b0; end
      default:    ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops the multiplexed 7-segment bus, accepts each digit after a stable dwell and
// publishes whole frames. Define SEG7_SCAN_DP_EN to add dp_n / digit_dp capture.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
`ifdef SEG7_SCAN_DP_EN
  input  logic                  dp_n,
  output logic [DIGITS-1:0]     digit_dp,
`endif
  output logic [4*DIGITS-1:0]   digit_bcd,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYC);

  logic [6:0]              seg_s, seg_p;
  logic [DIGITS-1:0]       an_s, an_p;
  logic                    dp_same;
  logic [DIGITS-1:0]       sel;
  logic                    onehot;
  logic                    same;
  logic [IDX_W-1:0]        sel_idx;
  logic [CNT_W-1:0]        count, count_nxt;
  logic                    capture;
  logic [DIGITS-1:0]       seen, seen_nxt;
  logic                    full;
  logic [DIGITS-1:0][3:0]  shadow_bcd;
  logic [DIGITS-1:0]       shadow_err;
  logic [3:0]              dec_nib;
  logic                    dec_err;

  seg7_pattern_to_bcd u_dec (
    .pattern (seg_s),
    .nibble  (dec_nib),
    .err     (dec_err)
  );

  // Sample stage plus one-deep history used for the stability compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s <= '0;
      an_s  <= '0;
      seg_p <= '0;
      an_p  <= '0;
    end else begin
      seg_s <= seg_n;
      an_s  <= an_n;
      seg_p <= seg_s;
      an_p  <= an_s;
    end
  end

`ifdef SEG7_SCAN_DP_EN
  logic dp_s, dp_p;
  logic [DIGITS-1:0] shadow_dp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s      <= 1'b0;
      dp_p      <= 1'b0;
      shadow_dp <= '0;
      digit_dp  <= '0;
    end else begin
      dp_s <= dp_n;
      dp_p <= dp_s;
      if (capture)
        shadow_dp[sel_idx] <= ~dp_s;
      if (full)
        digit_dp <= shadow_dp;
    end
  end

  assign dp_same = (dp_s == dp_p);
`else
  assign dp_same = 1'b1;
`endif

  assign sel    = ~an_s;
  assign onehot = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
  assign same   = (seg_s == seg_p) && (an_s == an_p) && dp_same;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (sel[i])
        sel_idx = IDX_W'(i);
  end

  always_comb begin
    count_nxt = '0;
    if (onehot && same)
      count_nxt = (count == CNT_FULL) ? count : count + CNT_W'(1);
    else if (onehot)
      count_nxt = CNT_W'(1);
  end

  // Saturation guarantees a single capture per dwell
  assign capture = (count_nxt == CNT_FULL) && (count != CNT_FULL);
  assign full    = &seen;

  always_comb begin
    seen_nxt = full ? '0 : seen;
    if (capture)
      seen_nxt = seen_nxt | sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      seen        <= '0;
      shadow_bcd  <= '0;
      shadow_err  <= '0;
      digit_bcd   <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      count       <= count_nxt;
      seen        <= seen_nxt;
      frame_valid <= full;
      if (capture) begin
        shadow_bcd[sel_idx] <= dec_nib;
        shadow_err[sel_idx] <= dec_err;
      end
      // Publish reads the shadow before any same-edge capture lands in it
      if (full) begin
        digit_bcd <= shadow_bcd;
        digit_err <= shadow_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (DIGITS=4, STABLE_CYC=4).
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] digit_bcd;
  logic [3:0]  digit_err;
  logic        frame_valid;
`ifdef SEG7_SCAN_DP_EN
  logic        dp_n = 1'b1;
  logic [3:0]  digit_dp;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int base;

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYC(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
`ifdef SEG7_SCAN_DP_EN
    .dp_n        (dp_n),
    .digit_dp    (digit_dp),
`endif
    .digit_bcd   (digit_bcd),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (frame_valid)
      pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] pat, input int cyc, input logic dp);
    @(negedge clk);
    an_n  = an;
    seg_n = pat;
`ifdef SEG7_SCAN_DP_EN
    dp_n  = dp;
`else
    if (dp !== dp) $display("dp undefined");
`endif
    repeat (cyc) @(posedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] pat, input int cyc);
    logic [3:0] a;
    a = 4'hF;
    a[d] = 1'b0;
    drive(a, pat, cyc, 1'b1);
  endtask

  task automatic idle(input int cyc);
    drive(4'hF, 7'h7F, cyc, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_bcd", 32'(digit_bcd), 32'h0);
    chk("rst_err", 32'(digit_err), 32'h0);
    chk("rst_fv",  32'(frame_valid), 32'h0);
    rst = 1'b0;

    // 1: digits 1,2,3,4 held 6 cycles; check publish latency on the last digit
    base = pulses;
    drive(4'b1110, 7'h79, 6, 1'b0);
    show(1, 7'h24, 6);
    show(2, 7'h30, 6);
    @(negedge clk);
    an_n  = 4'b0111;
    seg_n = 7'h19;
    repeat (5) @(posedge clk);
    #1 chk("t1_fv_before", 32'(frame_valid), 32'h0);
    @(posedge clk);
    #1 chk("t1_fv_pulse", 32'(frame_valid), 32'h1);
    chk("t1_bcd", 32'(digit_bcd), 32'h4321);
    chk("t1_err", 32'(digit_err), 32'h0);
`ifdef SEG7_SCAN_DP_EN
    chk("t1_dp", 32'(digit_dp), 32'h1);
`endif
    @(posedge clk);
    #1 chk("t1_fv_after", 32'(frame_valid), 32'h0);
    idle(3);
    chk("t1_pulses", 32'(pulses - base), 32'h1);

    // 2: digit 2 dwell too short; frame completes on digit 2 of the second scan
    base = pulses;
    show(0, 7'h12, 6);
    show(1, 7'h02, 6);
    show(2, 7'h78, 3);
    show(3, 7'h00, 6);
    idle(3);
    chk("t2_no_pulse", 32'(pulses - base), 32'h0);
    chk("t2_hold", 32'(digit_bcd), 32'h4321);
    show(0, 7'h10, 6);
    show(1, 7'h00, 6);
    show(2, 7'h78, 6);
    show(3, 7'h02, 6);
    idle(3);
    chk("t2_pulses", 32'(pulses - base), 32'h1);
    chk("t2_bcd", 32'(digit_bcd), 32'h8789);

    // 3: invalid pattern on digit 1, blank on digit 3
    do_reset();
    chk("t3_rst_bcd", 32'(digit_bcd), 32'h0);
    base = pulses;
    show(0, 7'h40, 6);
    show(1, 7'h55, 6);
    show(2, 7'h79, 6);
    show(3, 7'h7F, 6);
    idle(3);
    chk("t3_pulses", 32'(pulses - base), 32'h1);
    chk("t3_bcd", 32'(digit_bcd), 32'hF1F0);
    chk("t3_err", 32'(digit_err), 32'h2);

    // 4: invalid digit selects between digits never capture
    base = pulses;
    show(0, 7'h24, 6);
    drive(4'b1100, 7'h30, 8, 1'b1);
    show(1, 7'h30, 6);
    drive(4'b1111, 7'h19, 8, 1'b1);
    show(2, 7'h19, 6);
    drive(4'b1100, 7'h12, 8, 1'b1);
    chk("t4_no_pulse", 32'(pulses - base), 32'h0);
    show(3, 7'h12, 6);
    idle(3);
    chk("t4_pulses", 32'(pulses - base), 32'h1);
    chk("t4_bcd", 32'(digit_bcd), 32'h5432);
    chk("t4_err", 32'(digit_err), 32'h0);

    // 5: reset mid-frame clears outputs at once; then a full scan is needed
    show(0, 7'h40, 6);
    show(1, 7'h79, 6);
    show(2, 7'h24, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_bcd", 32'(digit_bcd), 32'h0);
    chk("t5_rst_fv", 32'(frame_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = pulses;
    show(2, 7'h24, 6);
    show(3, 7'h30, 6);
    idle(3);
    chk("t5_no_pulse", 32'(pulses - base), 32'h0);
    show(0, 7'h40, 6);
    show(1, 7'h79, 6);
    idle(3);
    chk("t5_pulses", 32'(pulses - base), 32'h1);
    chk("t5_bcd", 32'(digit_bcd), 32'h3210);

    // 6: each digit held exactly STABLE_CYC cycles is accepted
    do_reset();
    base = pulses;
    show(0, 7'h02, 4);
    show(1, 7'h78, 4);
    show(2, 7'h00, 4);
    show(3, 7'h10, 4);
    idle(4);
    chk("t6_pulses", 32'(pulses - base), 32'h1);
    chk("t6_bcd", 32'(digit_bcd), 32'h9876);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
